// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for fetch and decode
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FS_RUN,
    FS_HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic               valid;
  } fetch_out_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage bus: instruction memory, decode and execute side
interface instr_fetch_if
  import cpu_pkg::*;
#(
  parameter int IMEM_AW = 11
);

  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_rd;
  logic [31:0]        imem_rdata;
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               halt;
  logic [INSTR_W-1:0] instr_o;
  logic [31:0]        pc_o;
  logic               valid_o;

  modport master (
    output imem_addr, imem_rd, instr_o, pc_o, valid_o,
    input  imem_rdata, stall, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_addr, imem_rd, instr_o, pc_o, valid_o,
    output imem_rdata, stall, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry instruction+PC holding register
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] wr_instr,
  input  logic [31:0]        wr_pc,
  output logic               full,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc
);

  // Clear wins over load so a flush can never leave a stale word behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= wr_instr;
      pc    <= wr_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage; IFETCH_PERF_EN adds fetch/stall counters
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 11
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_if.master      bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [31:0]        pc_q;
  logic               inflight_q;
  logic [31:0]        inflight_pc_q;
  fetch_out_t         out_q;
  logic               skid_v;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc;
  logic               held;
  logic               issue;
  logic               skid_load;
  logic               skid_clear;

  // Decode is holding the current output; nothing may move into it.
  assign held = out_q.valid && bus.stall;

  // A new read is only allowed when its data is guaranteed a landing slot.
  assign issue = (state == FS_RUN) && !rst && !bus.redirect && !bus.halt
                 && !skid_v && !held;

  assign skid_load  = !bus.redirect && !bus.halt && inflight_q && held;
  assign skid_clear = bus.redirect || bus.halt || (!held && skid_v);

  assign bus.imem_rd   = issue;
  assign bus.imem_addr = pc_q[IMEM_AW+1:2];
  assign bus.instr_o   = out_q.instr;
  assign bus.pc_o      = out_q.pc;
  assign bus.valid_o   = out_q.valid;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .wr_instr (bus.imem_rdata),
    .wr_pc    (inflight_pc_q),
    .full     (skid_v),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FS_RUN;
    else     state <= state_next;
  end

  // Redirect beats halt; HALTED is left only by redirect or reset.
  always_comb begin
    state_next = state;
    if (bus.redirect)  state_next = FS_RUN;
    else if (bus.halt) state_next = FS_HALTED;
  end

  // PC, in-flight tracking and the decode-facing output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_q         <= '0;
    end else if (bus.redirect) begin
      pc_q        <= word_align(bus.redirect_pc);
      inflight_q  <= 1'b0;
      out_q.valid <= 1'b0;
    end else if (bus.halt) begin
      inflight_q  <= 1'b0;
      out_q.valid <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end
      if (!held) begin
        if (skid_v) begin
          out_q <= '{instr: skid_instr, pc: skid_pc, valid: 1'b1};
        end else if (inflight_q) begin
          out_q <= '{instr: bus.imem_rdata, pc: inflight_pc_q, valid: 1'b1};
        end else begin
          out_q.valid <= 1'b0;
        end
      end
    end
  end

`ifdef IFETCH_PERF_EN
  // Free-running event counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + {31'd0, issue};
      stall_cnt <= stall_cnt + {31'd0, held};
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  instr_fetch_if #(.IMEM_AW(11)) bus ();

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  instr_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Synchronous instruction memory, one cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_rdata <= mem[bus.imem_addr];
  end

  // Reference: word at byte address pc holds E000_0000 | word index (11-bit).
  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'hE000_0000 | {21'd0, pc[12:2]};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.halt = 1'b0;
    bus.redirect_pc = '0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.halt = 1'b0;
    bus.redirect_pc = '0;
    next_cycle();
    next_cycle();
    #1;
    checks += 4;
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%0h expected=0", bus.valid_o); end
    if (bus.pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%0h expected=0", bus.pc_o); end
    if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr actual=%0h expected=0", bus.instr_o); end
    if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL reset_rd actual=%0h expected=0", bus.imem_rd); end
`ifdef IFETCH_PERF_EN
    checks += 2;
    if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL reset_fetch_cnt actual=%0d expected=0", fetch_cnt); end
    if (stall_cnt !== 32'h0) begin failures++; $display("FAIL reset_stall_cnt actual=%0d expected=0", stall_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 10; k++) begin
      #1;
      checks += 2;
      if (bus.imem_rd !== 1'b1) begin failures++; $display("FAIL stream_rd cycle=%0d actual=%0h expected=1", k, bus.imem_rd); end
      if (bus.imem_addr !== 11'(k)) begin failures++; $display("FAIL stream_addr cycle=%0d actual=%0h expected=%0h", k, bus.imem_addr, k); end
      if (k >= 2) begin
        checks += 3;
        if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL stream_valid cycle=%0d actual=%0h expected=1", k, bus.valid_o); end
        if (bus.pc_o !== 32'(4 * (k - 2))) begin failures++; $display("FAIL stream_pc cycle=%0d actual=%0h expected=%0h", k, bus.pc_o, 4 * (k - 2)); end
        if (bus.instr_o !== exp_instr(32'(4 * (k - 2)))) begin failures++; $display("FAIL stream_instr cycle=%0d actual=%0h expected=%0h", k, bus.instr_o, exp_instr(32'(4 * (k - 2)))); end
      end else begin
        checks++;
        if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL stream_early_valid cycle=%0d actual=%0h expected=0", k, bus.valid_o); end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    pulse_reset();
    for (int k = 0; k < 4; k++) next_cycle();
    for (int k = 0; k < 3; k++) begin
      bus.stall = 1'b1;
      #1;
      checks += 4;
      if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL stall_valid n=%0d actual=%0h expected=1", k, bus.valid_o); end
      if (bus.pc_o !== 32'h8) begin failures++; $display("FAIL stall_pc n=%0d actual=%0h expected=8", k, bus.pc_o); end
      if (bus.instr_o !== exp_instr(32'h8)) begin failures++; $display("FAIL stall_instr n=%0d actual=%0h expected=%0h", k, bus.instr_o, exp_instr(32'h8)); end
      if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL stall_rd n=%0d actual=%0h expected=0", k, bus.imem_rd); end
      next_cycle();
    end
    bus.stall = 1'b0;
    #1;
    checks += 2;
    if (bus.pc_o !== 32'h8) begin failures++; $display("FAIL release_pc actual=%0h expected=8", bus.pc_o); end
    if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL release_rd_skid_full actual=%0h expected=0", bus.imem_rd); end
`ifdef IFETCH_PERF_EN
    checks += 2;
    if (stall_cnt !== 32'd3) begin failures++; $display("FAIL stall_cnt actual=%0d expected=3", stall_cnt); end
    if (fetch_cnt !== 32'd4) begin failures++; $display("FAIL fetch_cnt actual=%0d expected=4", fetch_cnt); end
`endif
    next_cycle();
    #1;
    checks += 4;
    if (bus.pc_o !== 32'hC || bus.valid_o !== 1'b1) begin failures++; $display("FAIL skid_out_pc actual=%0h/%0h expected=c/1", bus.pc_o, bus.valid_o); end
    if (bus.instr_o !== exp_instr(32'hC)) begin failures++; $display("FAIL skid_out_instr actual=%0h expected=%0h", bus.instr_o, exp_instr(32'hC)); end
    if (bus.imem_rd !== 1'b1) begin failures++; $display("FAIL resume_rd actual=%0h expected=1", bus.imem_rd); end
    if (bus.imem_addr !== 11'd4) begin failures++; $display("FAIL resume_addr actual=%0h expected=4", bus.imem_addr); end
    next_cycle();
    #1;
    checks++;
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL bubble_valid actual=%0h expected=0", bus.valid_o); end
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks += 2;
      if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'(16 + 4 * k)) begin failures++; $display("FAIL after_stall_pc actual=%0h/%0h expected=%0h/1", bus.pc_o, bus.valid_o, 16 + 4 * k); end
      if (bus.instr_o !== exp_instr(32'(16 + 4 * k))) begin failures++; $display("FAIL after_stall_instr actual=%0h expected=%0h", bus.instr_o, exp_instr(32'(16 + 4 * k))); end
      next_cycle();
    end
  endtask

  task automatic test_redirect_skid();
    pulse_reset();
    for (int k = 0; k < 4; k++) next_cycle();
    bus.stall = 1'b1;
    next_cycle();
    next_cycle();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    #1;
    checks++;
    if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL redir_cycle_rd actual=%0h expected=0", bus.imem_rd); end
    next_cycle();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    #1;
    checks += 3;
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL redir_flush_valid actual=%0h expected=0", bus.valid_o); end
    if (bus.imem_rd !== 1'b1) begin failures++; $display("FAIL redir_issue_rd actual=%0h expected=1", bus.imem_rd); end
    if (bus.imem_addr !== 11'h40) begin failures++; $display("FAIL redir_issue_addr actual=%0h expected=40", bus.imem_addr); end
    next_cycle();
    #1;
    checks++;
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL redir_r2_valid actual=%0h expected=0", bus.valid_o); end
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks += 2;
      if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'(32'h100 + 4 * k)) begin failures++; $display("FAIL redir_out_pc actual=%0h/%0h expected=%0h/1", bus.pc_o, bus.valid_o, 32'h100 + 4 * k); end
      if (bus.instr_o !== exp_instr(32'(32'h100 + 4 * k))) begin failures++; $display("FAIL redir_out_instr actual=%0h expected=%0h", bus.instr_o, exp_instr(32'(32'h100 + 4 * k))); end
      next_cycle();
    end
  endtask

  task automatic test_halt();
    bus.halt = 1'b1;
    #1;
    checks++;
    if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL halt_cycle_rd actual=%0h expected=0", bus.imem_rd); end
    next_cycle();
    bus.halt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks += 2;
      if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL halted_rd n=%0d actual=%0h expected=0", k, bus.imem_rd); end
      if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL halted_valid n=%0d actual=%0h expected=0", k, bus.valid_o); end
      next_cycle();
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h20;
    next_cycle();
    bus.redirect = 1'b0;
    #1;
    checks += 2;
    if (bus.imem_rd !== 1'b1) begin failures++; $display("FAIL unhalt_rd actual=%0h expected=1", bus.imem_rd); end
    if (bus.imem_addr !== 11'h8) begin failures++; $display("FAIL unhalt_addr actual=%0h expected=8", bus.imem_addr); end
    next_cycle();
    next_cycle();
    #1;
    checks += 2;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h20) begin failures++; $display("FAIL unhalt_pc actual=%0h/%0h expected=20/1", bus.pc_o, bus.valid_o); end
    if (bus.instr_o !== exp_instr(32'h20)) begin failures++; $display("FAIL unhalt_instr actual=%0h expected=%0h", bus.instr_o, exp_instr(32'h20)); end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] seq [3];
    seq[0] = 32'hFFFF_FFFC;
    seq[1] = 32'h0000_0000;
    seq[2] = 32'h0000_0004;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    next_cycle();
    bus.redirect = 1'b0;
    next_cycle();
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks += 2;
      if (bus.valid_o !== 1'b1 || bus.pc_o !== seq[k]) begin failures++; $display("FAIL wrap_pc n=%0d actual=%0h/%0h expected=%0h/1", k, bus.pc_o, bus.valid_o, seq[k]); end
      if (bus.instr_o !== exp_instr(seq[k])) begin failures++; $display("FAIL wrap_instr n=%0d actual=%0h expected=%0h", k, bus.instr_o, exp_instr(seq[k])); end
      next_cycle();
    end
  endtask

  task automatic test_reset_midrun();
    pulse_reset();
    for (int k = 0; k < 4; k++) next_cycle();
    bus.stall = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL midrst_rd actual=%0h expected=0", bus.imem_rd); end
    next_cycle();
    rst = 1'b0;
    bus.stall = 1'b0;
    #1;
    checks += 5;
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid actual=%0h expected=0", bus.valid_o); end
    if (bus.pc_o !== 32'h0) begin failures++; $display("FAIL midrst_pc actual=%0h expected=0", bus.pc_o); end
    if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL midrst_instr actual=%0h expected=0", bus.instr_o); end
    if (bus.imem_rd !== 1'b1) begin failures++; $display("FAIL midrst_restart_rd actual=%0h expected=1", bus.imem_rd); end
    if (bus.imem_addr !== 11'h0) begin failures++; $display("FAIL midrst_restart_addr actual=%0h expected=0", bus.imem_addr); end
`ifdef IFETCH_PERF_EN
    checks += 2;
    if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL midrst_fetch_cnt actual=%0d expected=0", fetch_cnt); end
    if (stall_cnt !== 32'h0) begin failures++; $display("FAIL midrst_stall_cnt actual=%0d expected=0", stall_cnt); end
`endif
    next_cycle();
    next_cycle();
    #1;
    checks += 2;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h0) begin failures++; $display("FAIL midrst_first_pc actual=%0h/%0h expected=0/1", bus.pc_o, bus.valid_o); end
    if (bus.instr_o !== exp_instr(32'h0)) begin failures++; $display("FAIL midrst_first_instr actual=%0h expected=%0h", bus.instr_o, exp_instr(32'h0)); end
    next_cycle();
  endtask

  // Random stall/redirect/halt traffic against an in-order stream model:
  // every presented word must be the next PC of the current stream.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        halted;
    logic        held;
    int          idle;
    bus.stall = 1'b0;
    bus.halt = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = $urandom() & 32'h0000_1FFF;
    exp_pc = {bus.redirect_pc[31:2], 2'b00};
    halted = 1'b0;
    held = 1'b0;
    idle = 0;
    next_cycle();
    for (int n = 0; n < 3000; n++) begin
      bus.stall = ($urandom_range(99) < 30);
      bus.redirect = ($urandom_range(99) < 3);
      bus.halt = ($urandom_range(199) < 3);
      bus.redirect_pc = ($urandom_range(3) == 0) ? $urandom() : ($urandom() & 32'h0000_1FFF);
      #1;
      if (halted) begin
        checks += 2;
        if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL rnd_halted_valid n=%0d actual=%0h expected=0", n, bus.valid_o); end
        if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL rnd_halted_rd n=%0d actual=%0h expected=0", n, bus.imem_rd); end
      end
      if (bus.valid_o === 1'b1) begin
        checks += 2;
        if (bus.pc_o !== exp_pc) begin failures++; $display("FAIL rnd_pc n=%0d actual=%0h expected=%0h", n, bus.pc_o, exp_pc); end
        if (bus.instr_o !== exp_instr(exp_pc)) begin failures++; $display("FAIL rnd_instr n=%0d actual=%0h expected=%0h", n, bus.instr_o, exp_instr(exp_pc)); end
      end
      if (held) begin
        checks++;
        if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL rnd_hold n=%0d actual=%0h expected=1", n, bus.valid_o); end
      end
      if (bus.valid_o === 1'b1 || halted) idle = 0;
      else idle++;
      checks++;
      if (idle > 2) begin failures++; $display("FAIL rnd_starved n=%0d idle=%0d limit=2", n, idle); end
      if (bus.redirect) begin
        exp_pc = {bus.redirect_pc[31:2], 2'b00};
        halted = 1'b0;
        held = 1'b0;
        idle = 0;
      end else if (bus.halt) begin
        halted = 1'b1;
        held = 1'b0;
      end else begin
        held = bus.valid_o && bus.stall;
        if (bus.valid_o && !bus.stall) exp_pc = exp_pc + 32'd4;
      end
      next_cycle();
    end
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.halt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hE000_0000 | 32'(i);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_skid();
    test_halt();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Presents a registered `{instr, pc, valid}` triple to decode, holding it under decode back-pressure via a one-entry skid buffer.
- Handles branch/BX redirects from execute and stops fetching when decode reports HALT.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: byte address of the first fetch after reset.
- `IMEM_AW`, default `11`: instruction-memory word-address width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  IMEM_AW  word address, equal to `pc_q[IMEM_AW+1:2]`.
- `imem_rd`  out  1  read strobe; data is returned the following cycle.
- `imem_rdata`  in  32  read data, valid in the cycle after `imem_rd`.
- `stall`  in  1  decode cannot accept; the current output must be held.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  target byte address; bits [1:0] are ignored (treated as 0).
- `halt`  in  1  decode has seen HALT; stop fetching.
- `instr_o`  out  32  fetched instruction.
- `pc_o`  out  32  byte address of `instr_o`.
- `valid_o`  out  1  `instr_o` and `pc_o` are meaningful.
- `fetch_cnt`  out  32  number of issued reads. Present only with `IFETCH_PERF_EN`.
- `stall_cnt`  out  32  number of `valid_o && stall` cycles. Present only with `IFETCH_PERF_EN`.

## Operation
- States: `RUN`, `HALTED`. Reset enters `RUN`.
- Registers:
  - `pc_q`: next fetch address.
  - `inflight_q`, `inflight_pc_q`: a read is returning this cycle, and its address.
  - Skid: `skid_v`, `skid_instr`, `skid_pc`.
  - Output: `valid_o`, `instr_o`, `pc_o`.
- Issue rule: `imem_rd = RUN && !rst && !redirect && !halt && !skid_v && !(valid_o && stall)`.
  - On issue: `inflight_pc_q <= pc_q` and `pc_q <= pc_q + 4` (32-bit, wraps `FFFF_FFFC -> 0000_0000`).
- Output advance when `!valid_o || !stall`, in priority order:
  - If `skid_v`: load the skid entry into the output, then clear `skid_v`.
  - Else if `inflight_q`: load `imem_rdata` and `inflight_pc_q`.
  - Else: `valid_o <= 0`.
- Skid capture: when `inflight_q && valid_o && stall`, load `imem_rdata` and `inflight_pc_q` into the skid and set `skid_v`.
  - `inflight_q` and `skid_v` are never set together; this follows from the issue rule.
- Redirect (highest priority after `rst`, and overrides `stall`):
  - Next cycle: `valid_o=0`, `skid_v=0`, `inflight_q=0` (the returning word is dropped).
  - `pc_q <= {redirect_pc[31:2], 2'b00}`; state becomes `RUN` (this also exits `HALTED`).
- Halt, when sampled high with no redirect:
  - Next state `HALTED`; `skid_v`, `inflight_q` and `valid_o` are cleared.
  - In `HALTED`: no issue, `valid_o=0`.
  - Exit only by `redirect` or `rst`.
- Simultaneous `redirect` and `halt`: redirect wins, state `RUN`.
- Reset values:
  - `pc_q=RESET_PC`, `valid_o=0`, `instr_o=0`, `pc_o=0`.
  - `skid_v=0`, `inflight_q=0`, `imem_rd=0`, state `RUN`.
  - Counters = 0.
- `rst` mid-operation discards all in-flight and buffered words.

## Timing
- Read issued in cycle T: memory returns data in T+1; `valid_o` is high in T+2.
  - Fetch-to-decode latency is 2 cycles; throughput is 1 instruction/cycle with no stall.
- First `imem_rd` occurs in the first cycle with `rst` low; first `valid_o` two cycles later.
- Redirect in cycle R: `valid_o=0` in R+1; issue at `redirect_pc` in R+1; `valid_o` in R+3.
- Stall release with `skid_v` set: the skid word appears in the next cycle. Issue resumes the cycle after the skid drains, giving one bubble.

## Configuration
- `IFETCH_PERF_EN` defined:
  - Adds `fetch_cnt` (+1 per `imem_rd`) and `stall_cnt` (+1 per `valid_o && stall` cycle).
  - Both are 32-bit, wrap, reset to 0 and are unaffected by redirect or halt.
- Undefined: neither the ports nor the counter logic exist; all other behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds:
  - `INSTR_W=32`.
  - Default `RESET_PC`.
  - Fetch state enum `fetch_state_t {FS_RUN, FS_HALTED}`.
  - `fetch_out_t` struct `{instr, pc, valid}`, shared with decode.
- Sub-module `fetch_skid_buf`: one-entry instruction+PC holding register with load and clear controls.

## Test plan
- Reset, `RESET_PC=0`, memory word i = `32'hE000_0000|i`, no stall -> `imem_rd` in cycle 0; `valid_o` from cycle 2 with `pc_o` 0,4,8,… and matching `instr_o`.
- `stall` held 3 cycles while `pc_o=8` -> `pc_o` stays 8; skid holds 12; `imem_rd=0` while the skid is full. After release: 12, 16 in order, with no loss or duplication. With the macro defined: `stall_cnt=3`.
- `redirect`, `redirect_pc=32'h0000_0103`, during stall with skid full -> next cycle `valid_o=0`; `imem_addr=0x40` the same cycle; `pc_o=0x100` two cycles later; the stale skid word is never output.
- `halt` pulse -> `imem_rd=0` from the next cycle and `valid_o=0` for 10 cycles; then `redirect` to `0x20` -> `pc_o=0x20` three cycles after the redirect.
- `redirect` to `32'hFFFF_FFFC` -> `pc_o` sequence `FFFF_FFFC`, `0000_0000`, `0000_0004`.
- `rst` asserted for one cycle with skid full and a read in flight -> next cycle all outputs at reset values; fetch restarts at `RESET_PC`.
